async_fifo_wptr_full: RTL and testbench

ASYNC_FIFO_WPTR_FULL -- requirements
Module: async_fifo_wptr_full

---
 rtl/async_fifo_pkg.sv | 29 ++
 rtl/async_fifo_sync_r2w.sv | 34 +++
 rtl/async_fifo_wptr_full.sv | 88 ++++++++
 tb/tb_async_fifo_wptr_full.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared async FIFO package: Gray-code helpers used by both the write-side
// and read-side pointer blocks.
package async_fifo_pkg;

  // Helpers work on a wide vector; callers zero-extend their pointer into it
  // and cast the result back down to their own pointer width.  Zero-extension
  // is harmless for both conversions because leading zeros contribute nothing
  // to either XOR chain.
  localparam int GRAY_FN_W = 32;

  typedef logic [GRAY_FN_W-1:0] gray_vec_t;

  // Binary to reflected Gray code.
  function automatic gray_vec_t bin2gray(input gray_vec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it, computed here as a log-depth prefix XOR.
  function automatic gray_vec_t gray2bin(input gray_vec_t gray);
    gray_vec_t bin;
    bin = gray;
    for (int s = 1; s < GRAY_FN_W; s = s << 1) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_sync_r2w.sv
// Two-flop synchronizer bringing the read-domain Gray pointer into wclk.
module async_fifo_sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] wq1_d, wq1_q;
  logic [WIDTH-1:0] wq2_d, wq2_q;

  // Next-state for the two synchronizer stages: a plain shift, no logic
  // may touch the asynchronous input before the second flop.
  always_comb begin
    wq1_d = d;
    wq2_d = wq1_q;
  end

  // Synchronizer flops, cleared immediately by the write-domain reset.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= wq1_d;
      wq2_q <= wq2_d;
    end
  end

  assign q = wq2_q;

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and status block of the async FIFO: owns the binary and
// Gray write pointers, synchronizes the read pointer, and produces full,
// almost-full, occupancy and a sticky overflow flag.
module async_fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                ovf_clr,
  output logic                wclken,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                overflow
);

  localparam int PW = ADDRSIZE + 1;

  // Full when the write Gray pointer equals the read Gray pointer with its
  // two MSBs flipped: one lap ahead in the binary domain.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wq2;
  logic [PW-1:0] rbin_sync;

  logic [PW-1:0] wbin_d, wbin_q;
  logic [PW-1:0] wptr_d, wptr_q;
  logic [PW-1:0] wlevel_d, wlevel_q;
  logic          wfull_d, wfull_q;
  logic          wafull_d, wafull_q;
  logic          overflow_d, overflow_q;

  async_fifo_sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .wclk (wclk),
    .wrst (wrst),
    .d    (rptr),
    .q    (wq2)
  );

  // Next-state equations; a write and a newly synchronized read pointer on
  // the same edge are both folded into the same computation.
  always_comb begin
    wclken     = winc & ~wfull_q;
    wbin_d     = wbin_q + PW'(wclken);
    wptr_d     = PW'(bin2gray(GRAY_FN_W'(wbin_d)));
    rbin_sync  = PW'(gray2bin(GRAY_FN_W'(wq2)));
    wlevel_d   = wbin_d - rbin_sync;
    wfull_d    = (wptr_d == (wq2 ^ FULL_MASK));
    wafull_d   = (GRAY_FN_W'(wlevel_d) >= GRAY_FN_W'(AFULL_LVL));
    overflow_d = (winc & wfull_q) | (overflow_q & ~ovf_clr);
  end

  // Pointer and status registers, all cleared immediately on reset.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      wlevel_q   <= '0;
      wfull_q    <= 1'b0;
      wafull_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wptr_d;
      wlevel_q   <= wlevel_d;
      wfull_q    <= wfull_d;
      wafull_q   <= wafull_d;
      overflow_q <= overflow_d;
    end
  end

  assign waddr    = wbin_q[ADDRSIZE-1:0];
  assign wptr     = wptr_q;
  assign wfull    = wfull_q;
  assign wafull   = wafull_q;
  assign wlevel   = wlevel_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Self-checking bench for async_fifo_wptr_full with ADDRSIZE=4, AFULL_LVL=12.
module tb_async_fifo_wptr_full;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] rptr;
  logic       ovf_clr;
  logic       wclken;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  async_fifo_wptr_full #(
    .ADDRSIZE  (4),
    .AFULL_LVL (12)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .winc     (winc),
    .rptr     (rptr),
    .ovf_clr  (ovf_clr),
    .wclken   (wclken),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel),
    .overflow (overflow)
  );

  // Free-running write clock, period 10.
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  typedef struct {
    logic winc;
    logic ovf_clr;
    int   rcount;
    logic exp_wclken;
    logic exp_wfull;
    logic exp_wafull;
    int   exp_wlevel;
    logic exp_ovf;
  } vec_t;

  typedef struct {
    int         waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    int         wlevel;
    logic       ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  // Reference model: occupancy-based, tracking counts rather than Gray codes.
  int   m_wcount;
  int   m_wq1;
  int   m_wq2;
  logic m_full;
  logic m_ovf;

  function automatic logic [4:0] tb_gray(input int b);
    logic [5:0] v;
    logic [4:0] g;
    v = b[5:0];
    v[5] = 1'b0;
    for (int i = 0; i < 5; i++) g[i] = v[i] ^ v[i+1];
    return g;
  endfunction

  function automatic int mod32(input int x);
    return ((x % 32) + 32) % 32;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_wcount = 0;
    m_wq1    = 0;
    m_wq2    = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    sbq.delete();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_wclken"},   int'(wclken),   0);
    check({tag, "_waddr"},    int'(waddr),    0);
    check({tag, "_wptr"},     int'(wptr),     0);
    check({tag, "_wfull"},    int'(wfull),    0);
    check({tag, "_wafull"},   int'(wafull),   0);
    check({tag, "_wlevel"},   int'(wlevel),   0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // outputs, and push the model's post-edge expectation to the scoreboard.
  task automatic applyStimulus(input logic winc_i, input logic clr_i, input int rcount_i);
    exp_t e;
    logic wr;
    int   nw;
    int   lvl;
    winc    = winc_i;
    ovf_clr = clr_i;
    rptr    = tb_gray(mod32(rcount_i));
    #1;
    wr = winc_i && !m_full;
    check("pre_wclken", int'(wclken), int'(wr));
    check("pre_waddr",  int'(waddr),  m_wcount % 16);
    nw       = mod32(m_wcount + (wr ? 1 : 0));
    lvl      = mod32(nw - m_wq2);
    e.waddr  = nw % 16;
    e.wptr   = tb_gray(nw);
    e.wlevel = lvl;
    e.wfull  = (lvl == 16);
    e.wafull = (lvl >= 12);
    e.ovf    = (winc_i && m_full) || (m_ovf && !clr_i);
    sbq.push_back(e);
    m_wq2    = m_wq1;
    m_wq1    = mod32(rcount_i);
    m_wcount = nw;
    m_full   = e.wfull;
    m_ovf    = e.ovf;
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL sb_underflow actual=0 expected=1 entries at t=%0t", $time);
    end else begin
      e = sbq.pop_front();
      check("sb_waddr",    int'(waddr),    e.waddr);
      check("sb_wptr",     int'(wptr),     int'(e.wptr));
      check("sb_wfull",    int'(wfull),    int'(e.wfull));
      check("sb_wafull",   int'(wafull),   int'(e.wafull));
      check("sb_wlevel",   int'(wlevel),   e.wlevel);
      check("sb_overflow", int'(overflow), int'(e.ovf));
    end
  endtask

  task automatic step(input logic winc_i, input logic clr_i, input int rcount_i);
    applyStimulus(winc_i, clr_i, rcount_i);
    @(posedge wclk);
    @(negedge wclk);
    checkOutput();
  endtask

  task automatic doReset(input string tag);
    wrst    = 1'b1;
    winc    = 1'b0;
    ovf_clr = 1'b0;
    rptr    = '0;
    #1;
    checkAllZero(tag);
    @(negedge wclk);
    wrst = 1'b0;
    modelReset();
  endtask

  function automatic vec_t mkvec(input logic wi, input logic ci, input int rc,
                                 input logic ek, input logic ef, input logic ea,
                                 input int el, input logic eo);
    vec_t v;
    v.winc = wi; v.ovf_clr = ci; v.rcount = rc;
    v.exp_wclken = ek; v.exp_wfull = ef; v.exp_wafull = ea;
    v.exp_wlevel = el; v.exp_ovf = eo;
    return v;
  endfunction

  initial begin
    logic [4:0] prev_wptr;
    logic [3:0] prev_waddr;
    int         wraps;
    int         full_seen;
    int         rc;

    // Fill: 16 writes against an idle reader.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mkvec(1'b1, 1'b0, 0, 1'b1, (k == 15), (k + 1 >= 12), k + 1, 1'b0));
    // Three writes while full: ignored, overflow set.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkvec(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 16, 1'b1));
    vecs.push_back(mkvec(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 16, 1'b1)); // sticky
    vecs.push_back(mkvec(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 16, 1'b0)); // clear
    vecs.push_back(mkvec(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 16, 1'b1)); // set wins
    vecs.push_back(mkvec(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 16, 1'b0)); // clear
    // Drain one word: full visible for two edges, gone on the third.
    vecs.push_back(mkvec(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 16, 1'b0));
    vecs.push_back(mkvec(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 16, 1'b0));
    vecs.push_back(mkvec(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    vecs.push_back(mkvec(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    // Refill the freed slot.
    vecs.push_back(mkvec(1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 16, 1'b0));

    wrst    = 1'b1;
    winc    = 1'b0;
    ovf_clr = 1'b0;
    rptr    = '0;
    modelReset();

    // Reset state, then release with winc low.
    @(negedge wclk);
    @(negedge wclk);
    checkAllZero("reset");
    wrst = 1'b0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    checkAllZero("post_release");

    // Table-driven fill / overflow / drain.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].winc, vecs[i].ovf_clr, vecs[i].rcount);
      check($sformatf("vec%0d_wclken", i), int'(wclken), int'(vecs[i].exp_wclken));
      @(posedge wclk);
      @(negedge wclk);
      checkOutput();
      check($sformatf("vec%0d_wfull", i),    int'(wfull),    int'(vecs[i].exp_wfull));
      check($sformatf("vec%0d_wafull", i),   int'(wafull),   int'(vecs[i].exp_wafull));
      check($sformatf("vec%0d_wlevel", i),   int'(wlevel),   vecs[i].exp_wlevel);
      check($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
      if (i == 15) check("fill_wptr", int'(wptr), 5'b11000);
      if (i == 18) check("ovf_waddr_hold", int'(waddr), 0);
    end

    // Wrap: 40 writes with the reader three writes behind.
    doReset("wrap_reset");
    wraps     = 0;
    full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      rc         = (i >= 3) ? i - 3 : 0;
      prev_wptr  = wptr;
      prev_waddr = waddr;
      step(1'b1, 1'b0, rc);
      check("wrap_onebit", $countones(prev_wptr ^ wptr), 1);
      if (prev_waddr == 4'd15 && waddr == 4'd0) wraps++;
      if (wfull) full_seen++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 37);
    check("wrap_count",    wraps, 2);
    check("wrap_fullseen", full_seen, 0);
    check("wrap_level",    int'(wlevel), 3);

    // Mid-operation asynchronous reset after 7 writes.
    doReset("mid_pre_reset");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0);
    check("mid_level7", int'(wlevel), 7);
    winc = 1'b0;
    #2;
    wrst = 1'b1;
    #1;
    checkAllZero("mid_async");
    @(negedge wclk);
    wrst = 1'b0;
    modelReset();
    step(1'b1, 1'b0, 0);
    check("mid_after_level", int'(wlevel), 1);

    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
